// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: opcodes, FSM encoding and status bit positions shared by the SPI memory responder
package spi_mem_pkg;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_WR_DATA, ST_RD_DATA, ST_STATUS, ST_IGNORE
  } state_t;
  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s = '0;
    s[STAT_WEL] = wel;
    s[STAT_WIP] = wip;
    return s;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchroniser with rise/fall detect for one asynchronous SPI pin
module spi_sync_edge
  import spi_mem_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;
  // sr[1:0] synchronise, sr[2] holds the previous synchronised value for edge detect
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) sr <= {3{RST_VAL}};
    else sr <= {sr[1:0], din};
  assign dout = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 serial memory slave with WEL/WIP status and paged writes
module spi_mem_responder
  import spi_mem_pkg::*;
#(
  parameter int MEM_AW     = 5,
  parameter int PAGE_AW    = 4,
  parameter int TWC_CYCLES = 64
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic SPI_SCK,
  input  logic SPI_CSn,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic SPI_MISO_OE,
  output logic BUSY
);
  localparam int TW = $clog2(TWC_CYCLES + 1);
  localparam logic [15:0] PG_MASK = 16'((1 << PAGE_AW) - 1);
  logic sck_q, sck_rise, sck_fall, cs_q, cs_rise, cs_fall, mosi_q, mosi_rise, mosi_fall;
  logic unused;
  state_t state, state_nx;
  logic [2:0] bit_cnt;
  logic [7:0] sh_in, sh_out, byte_in, mem_rd;
  logic [15:0] addr, addr_l, addr_inc, addr_pg;
  logic is_wr, wel, wip, wrote, miso_r, oe_r, byte_done;
  logic [TW-1:0] twc;
  logic [7:0] mem [2**MEM_AW];
  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.ACLK(ACLK), .ARESETn(ARESETn), .din(SPI_SCK), .dout(sck_q), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.ACLK(ACLK), .ARESETn(ARESETn), .din(SPI_CSn), .dout(cs_q), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.ACLK(ACLK), .ARESETn(ARESETn), .din(SPI_MOSI), .dout(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
  assign unused = ^{sck_q, cs_q, mosi_rise, mosi_fall};
  assign byte_in = {sh_in[6:0], mosi_q};
  assign byte_done = sck_rise && &bit_cnt && state != ST_IDLE && !cs_rise;
  assign addr_l = {addr[15:8], byte_in};
  assign addr_inc = addr + 16'd1;
  assign addr_pg = (addr & ~PG_MASK) | (addr_inc & PG_MASK);
  assign mem_rd = mem[(state == ST_ADDR_L) ? addr_l[MEM_AW-1:0] : addr_inc[MEM_AW-1:0]];
  assign SPI_MISO = miso_r & oe_r;
  assign SPI_MISO_OE = oe_r;
  assign BUSY = wip;
  // state register
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state <= ST_IDLE;
    else state <= state_nx;
  // next state: CSn rise aborts everything, CSn fall starts a command, otherwise advance per byte
  always_comb begin
    state_nx = state;
    if (cs_rise) state_nx = ST_IDLE;
    else if (cs_fall) state_nx = ST_CMD;
    else if (byte_done)
      case (state)
        ST_CMD:    state_nx = (byte_in == OP_RDSR) ? ST_STATUS :
                              (!wip && (byte_in == OP_READ || byte_in == OP_WRITE)) ? ST_ADDR_H : ST_IGNORE;
        ST_ADDR_H: state_nx = ST_ADDR_L;
        ST_ADDR_L: state_nx = is_wr ? ST_WR_DATA : ST_RD_DATA;
        default:   state_nx = state;
      endcase
  end
  // shift registers, address, status flags and write-cycle timer
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      bit_cnt <= '0;
      sh_in <= '0;
      sh_out <= '0;
      addr <= '0;
      is_wr <= 1'b0;
      wel <= 1'b0;
      wip <= 1'b0;
      wrote <= 1'b0;
      miso_r <= 1'b0;
      oe_r <= 1'b0;
      twc <= '0;
    end else begin
      if (wip) begin
        twc <= twc - TW'(1);
        if (twc == TW'(1)) wip <= 1'b0;
      end
      if (cs_fall) begin
        bit_cnt <= '0;
        wrote <= 1'b0;
      end else if (sck_rise && state != ST_IDLE) begin
        bit_cnt <= bit_cnt + 3'd1;
        sh_in <= byte_in;
      end
      if (cs_rise) begin
        miso_r <= 1'b0;
        oe_r <= 1'b0;
        if (state == ST_WR_DATA && wrote) begin
          wel <= 1'b0;
          wip <= 1'b1;
          twc <= TW'(TWC_CYCLES);
        end
      end else if (sck_fall && (state == ST_RD_DATA || state == ST_STATUS)) begin
        miso_r <= sh_out[7];
        sh_out <= {sh_out[6:0], 1'b0};
        oe_r <= 1'b1;
      end else if (byte_done)
        case (state)
          ST_CMD: begin
            if (!wip && byte_in == OP_WREN) wel <= 1'b1;
            if (!wip && byte_in == OP_WRDI) wel <= 1'b0;
            is_wr <= byte_in == OP_WRITE;
            sh_out <= status_byte(wel, wip);
          end
          ST_ADDR_H:  addr[15:8] <= byte_in;
          ST_ADDR_L: begin
            addr <= addr_l;
            sh_out <= mem_rd;
          end
          ST_RD_DATA: begin
            addr <= addr_inc;
            sh_out <= mem_rd;
          end
          ST_WR_DATA: begin
            addr <= addr_pg;
            if (wel) wrote <= 1'b1;
          end
          ST_STATUS:  sh_out <= status_byte(wel, wip);
          default:    ;
        endcase
    end
  // byte-wide memory write, left unreset so it maps onto RAM
  always_ff @(posedge ACLK)
    if (byte_done && state == ST_WR_DATA && wel) mem[addr[MEM_AW-1:0]] <= byte_in;
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: randomized SPI master with a scoreboarded reference memory model
module tb_spi_mem_responder;
  localparam int TWC = 600;
  localparam int HALF = 50;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic SPI_SCK = 1'b0;
  logic SPI_CSn = 1'b1;
  logic SPI_MOSI = 1'b0;
  logic SPI_MISO, SPI_MISO_OE, BUSY;
  logic [7:0] mem_m [32];
  logic wel_m = 1'b0;
  logic wip_m = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_busy = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] wdata [$];
  int req_q [$];
  event chk_ev;
  int vectors = 0;
  int miscompares = 0;

  spi_mem_responder #(.MEM_AW(5), .PAGE_AW(4), .TWC_CYCLES(TWC)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .SPI_SCK(SPI_SCK), .SPI_CSn(SPI_CSn),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    logic [7:0] sh, e;
    int n, r;
    n = 0;
    sh = '0;
    forever begin
      @(posedge SPI_SCK or posedge SPI_CSn or chk_ev);
      if (SPI_SCK === 1'b1 && SPI_CSn === 1'b0) begin
        vectors++;
        if (SPI_MISO_OE !== exp_oe || BUSY !== exp_busy || (SPI_MISO_OE !== 1'b1 && SPI_MISO !== 1'b0)) begin
          miscompares++;
          $display("FAIL bit_sample @%0t: oe=%b busy=%b miso=%b, expected oe=%b busy=%b", $time, SPI_MISO_OE, BUSY, SPI_MISO, exp_oe, exp_busy);
        end
        if (SPI_MISO_OE === 1'b1) begin
          sh = {sh[6:0], SPI_MISO};
          n++;
          if (n == 8) begin
            n = 0;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL miso_byte @%0t: got %02h, expected no byte", $time, sh);
            end else begin
              e = exp_q.pop_front();
              if (sh !== e) begin
                miscompares++;
                $display("FAIL miso_byte @%0t: got %02h, expected %02h", $time, sh, e);
              end
            end
          end
        end
      end
      if (SPI_CSn !== 1'b0) n = 0;
      while (req_q.size() > 0) begin
        r = req_q.pop_front();
        vectors++;
        if (r == 0) begin
          if (SPI_MISO_OE !== 1'b0 || SPI_MISO !== 1'b0 || BUSY !== exp_busy) begin
            miscompares++;
            $display("FAIL idle @%0t: oe=%b miso=%b busy=%b, expected oe=0 miso=0 busy=%b", $time, SPI_MISO_OE, SPI_MISO, BUSY, exp_busy);
          end
        end else if (exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL leftover: %0d expected bytes never seen, expected 0", exp_q.size());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int nbits, input logic oe);
    for (int i = 7; i > 7 - nbits; i--) begin
      SPI_MOSI = b[i];
      exp_oe = oe;
      #HALF SPI_SCK = 1'b1;
      #HALF SPI_SCK = 1'b0;
    end
  endtask

  task automatic idle_check();
    req_q.push_back(0);
    -> chk_ev;
    #1;
  endtask

  task automatic cs_low();
    SPI_CSn = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    SPI_CSn = 1'b1;
    SPI_MOSI = 1'b0;
    exp_oe = 1'b0;
    #(4 * HALF);
    idle_check();
  endtask

  task automatic op(input logic [7:0] code);
    cs_low();
    send(code, 8, 1'b0);
    if (!wip_m && code == 8'h06) wel_m = 1'b1;
    if (!wip_m && code == 8'h04) wel_m = 1'b0;
    cs_high();
  endtask

  task automatic rdsr(input int nb);
    cs_low();
    send(8'h05, 8, 1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back({6'b0, wel_m, wip_m});
      send(8'($urandom), 8, 1'b1);
    end
    cs_high();
  endtask

  task automatic rd(input logic [15:0] a, input int nb, input int part);
    logic act;
    act = !wip_m;
    cs_low();
    send(8'h03, 8, 1'b0);
    send(a[15:8], 8, 1'b0);
    send(a[7:0], 8, 1'b0);
    for (int i = 0; i < nb; i++) begin
      if (act) exp_q.push_back(mem_m[(int'(a) + i) % 32]);
      send(8'($urandom), 8, act);
    end
    send(8'($urandom), part, act);
    cs_high();
  endtask

  task automatic wr(input logic [15:0] a, input int part, input logic [7:0] pb);
    cs_low();
    send(8'h02, 8, 1'b0);
    send(a[15:8], 8, 1'b0);
    send(a[7:0], 8, 1'b0);
    foreach (wdata[i]) send(wdata[i], 8, 1'b0);
    send(pb, part, 1'b0);
    if (!wip_m && wel_m && wdata.size() > 0) begin
      foreach (wdata[i]) mem_m[(int'(a) % 32) / 16 * 16 + (int'(a) + i) % 16] = wdata[i];
      wel_m = 1'b0;
      wip_m = 1'b1;
      exp_busy = 1'b1;
    end
    cs_high();
  endtask

  task automatic wait_twc();
    #((TWC + 20) * 10);
    wip_m = 1'b0;
    exp_busy = 1'b0;
    idle_check();
  endtask

  initial begin
    #20 idle_check();
    #20 ARESETn = 1'b1;
    #100;
    for (int p = 0; p < 2; p++) begin
      op(8'h06);
      wdata.delete();
      for (int i = 0; i < 16; i++) wdata.push_back(8'($urandom));
      wr(16'(p * 16), 0, 8'h00);
      wait_twc();
    end
    rdsr(1);
    op(8'h06);
    wdata = '{8'hAA};
    wr(16'h00F0, 0, 8'h00);
    rdsr(1);
    op(8'h06);
    rdsr(1);
    wait_twc();
    rdsr(1);
    rd(16'h00F0, 1, 0);
    op(8'h06);
    rdsr(1);
    op(8'h04);
    wdata = '{8'h55};
    wr(16'h0001, 0, 8'h00);
    rd(16'h0001, 1, 0);
    rdsr(1);
    op(8'h06);
    wdata = '{8'h11, 8'h22, 8'h33};
    wr(16'h00FE, 0, 8'h00);
    wait_twc();
    rd(16'h001E, 2, 0);
    rd(16'h0010, 1, 0);
    rd(16'h001F, 2, 3);
    op(8'h06);
    wdata.delete();
    wr(16'h0004, 4, 8'h77);
    rdsr(1);
    rd(16'h0004, 1, 0);
    op(8'h04);
    op(8'h06);
    cs_low();
    send(8'h03, 8, 1'b0);
    send(8'h00, 8, 1'b0);
    send(8'h08, 8, 1'b0);
    send(8'hFF, 3, 1'b1);
    ARESETn = 1'b0;
    wel_m = 1'b0;
    exp_oe = 1'b0;
    #20 idle_check();
    SPI_CSn = 1'b1;
    #50 ARESETn = 1'b1;
    #200;
    rdsr(1);
    rd(16'h0008, 1, 0);
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 5))
        0: op(8'h06);
        1: op(8'h04);
        2: rdsr(int'($urandom_range(1, 2)));
        3: rd(16'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(0, 7)));
        4: begin
          if ($urandom_range(0, 1) == 1) op(8'h06);
          wdata.delete();
          repeat ($urandom_range(0, 4)) wdata.push_back(8'($urandom));
          wr(16'($urandom), int'($urandom_range(0, 7)), 8'($urandom));
          if (wip_m) begin
            if ($urandom_range(0, 1) == 1) rdsr(1);
            wait_twc();
          end
        end
        default: op(8'($urandom_range(7, 255)));
      endcase
    end
    req_q.push_back(1);
    -> chk_ev;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
